// File: rtl/bm_memory_arbiter.sv
// bm_memory_arbiter: round-robin arbiter that clears and then shares a single-port register file
module bm_memory_arbiter #(
    parameter int BITS      = 2,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [BITS-1:0]      wdata_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADDR_BITS-1:0] addr_b,
    input  logic [BITS-1:0]      wdata_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic [BITS-1:0]      rdata,
    output logic                 rvalid,
    output logic                 rvalid_id,
    output logic                 busy
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t                state, state_next;
    logic [ADDR_BITS-1:0]  clear_ptr;
    logic                  last;
    logic [BITS-1:0]       mem [DEPTH];
    logic                  gnt;
    logic                  acc_we;
    logic [ADDR_BITS-1:0]  acc_addr;
    logic [BITS-1:0]       acc_wdata;

    assign gnt       = gnt_a | gnt_b;
    assign acc_we    = gnt_b ? we_b : we_a;
    assign acc_addr  = gnt_b ? addr_b : addr_a;
    assign acc_wdata = gnt_b ? wdata_b : wdata_a;

    // Next state and grants; last = 1 means B was served most recently, so A wins a tie
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        if (state == CLEAR) begin
            busy       = 1'b1;
            state_next = (clear_ptr == ADDR_BITS'(DEPTH - 1)) ? SERVE : CLEAR;
        end else begin
            gnt_a = req_a & (~req_b | last);
            gnt_b = req_b & ~gnt_a;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // Memory array: zeroed by the sweep, written by granted writes; untouched while in reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR)    mem[clear_ptr] <= '0;
            else if (gnt && acc_we) mem[acc_addr] <= acc_wdata;
        end
    end

    // Sweep pointer, fairness history and registered read port
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_ptr <= '0;
            last      <= 1'b1;
            rvalid    <= 1'b0;
            rvalid_id <= 1'b0;
            rdata     <= '0;
        end else begin
            rvalid <= 1'b0;
            if (state == CLEAR) begin
                clear_ptr <= clear_ptr + 1'b1;
            end else if (gnt) begin
                last <= gnt_b;
                if (!acc_we) begin
                    rdata     <= mem[acc_addr];
                    rvalid    <= 1'b1;
                    rvalid_id <= gnt_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_bm_memory_arbiter.sv
// tb_bm_memory_arbiter: random and directed scoreboard bench for the clear-then-serve memory arbiter
module tb_bm_memory_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic       id;
        logic [1:0] data;
    } exp_t;

    logic       clock = 1'b1;
    logic       reset = 1'b1;
    logic [1:0] r_req = '0;
    logic [1:0] r_we  = '0;
    logic [1:0] r_addr [2];
    logic [1:0] r_wd   [2];
    logic       gnt_a, gnt_b, rvalid, rvalid_id, busy;
    logic [1:0] rdata;

    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       sb [$];
    logic [1:0] hold   = '0;
    logic [1:0] mg     = '0;
    logic [1:0] mm [DEPTH];
    int         busy_left = DEPTH;
    logic       last_b = 1'b1;
    int         mw;

    bm_memory_arbiter #(.BITS(2), .ADDR_BITS(2)) dut (
        .clock(clock), .reset(reset),
        .req_a(r_req[0]), .we_a(r_we[0]), .addr_a(r_addr[0]), .wdata_a(r_wd[0]),
        .req_b(r_req[1]), .we_b(r_we[1]), .addr_b(r_addr[1]), .wdata_b(r_wd[1]),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rdata(rdata), .rvalid(rvalid),
        .rvalid_id(rvalid_id), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: decides who should be served this cycle and what a read must return
    always @(negedge clock) begin
        if (reset) begin
            busy_left = DEPTH;
            last_b    = 1'b1;
            sb.delete();
            hold      = '0;
            mg        = '0;
            foreach (mm[i]) mm[i] = '0;
        end else begin
            chk("busy", busy, busy_left > 0);
            if (busy_left > 0) begin
                busy_left--;
                mg = '0;
            end else if (r_req == 2'b11) mg = last_b ? 2'b01 : 2'b10;
            else mg = r_req;
            chk("gnt_a", gnt_a, mg[0]);
            chk("gnt_b", gnt_b, mg[1]);
            if (mg != 2'b00) begin
                mw     = mg[1] ? 1 : 0;
                last_b = mg[1];
                if (r_we[mw]) mm[r_addr[mw]] = r_wd[mw];
                else sb.push_back('{mg[1], mm[r_addr[mw]]});
            end
        end
    end

    // Monitor: every edge either delivers the one queued read result or must stay quiet and hold rdata
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rvalid", rvalid, 1);
            chk("rvalid_id", rvalid_id, e.id);
            chk("rdata", rdata, e.data);
            hold = e.data;
        end else begin
            chk("rvalid_idle", rvalid, 0);
            chk("rdata_hold", rdata, hold);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
        r_req = r_req & ~mg;
    endtask

    task automatic issue(input int id, input int we, input int a, input int d);
        r_req[id]  = 1'b1;
        r_we[id]   = we[0];
        r_addr[id] = a[1:0];
        r_wd[id]   = d[1:0];
    endtask

    task automatic drain();
        int n = 0;
        while (r_req != 2'b00 && n < 50) begin
            step();
            n++;
        end
        chk("drain_timeout", r_req, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        r_req = '0;
        step();
        r_req = '0;
        reset = 1'b0;
    endtask

    initial begin
        r_addr[0] = '0; r_addr[1] = '0; r_wd[0] = '0; r_wd[1] = '0;
        #2;
        step();
        reset = 1'b0;
        issue(0, 0, 3, 0);
        drain();
        issue(0, 1, 1, 2);
        drain();
        issue(0, 0, 1, 0);
        drain();
        repeat (6) begin
            if (!r_req[0]) issue(0, 1, 0, 1);
            if (!r_req[1]) issue(1, 0, 0, 0);
            step();
        end
        drain();
        repeat (3) begin
            issue(1, 0, $urandom_range(3), 0);
            step();
        end
        issue(0, 0, 1, 0);
        issue(1, 0, 2, 0);
        drain();
        issue(0, 1, 2, 3);
        drain();
        issue(1, 0, 2, 0);
        do_reset();
        issue(1, 0, 2, 0);
        drain();
        repeat (10) step();
        repeat (400) begin
            if ($urandom_range(99) == 0) do_reset();
            else begin
                for (int id = 0; id < 2; id++)
                    if (!r_req[id] && $urandom_range(1) == 1)
                        issue(id, $urandom_range(1), $urandom_range(3), $urandom_range(3));
                step();
            end
        end
        drain();
        repeat (2) step();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
